// File: rtl/acum_ovf_capture.sv
// ---------------------------------------------------------------------------
// acum_ovf_capture
//   Watches the accumulator's data word and overflow flag. Every rising edge
//   of the overflow flag (while enabled) records a {data, timestamp} snapshot
//   into a small show-ahead FIFO that a consumer drains over valid/ready.
//   A saturating event counter and a sticky drop flag back a status block.
//
// Ports
//   e_clk        in   clock, all state on the rising edge
//   e_reset      in   asynchronous active-low reset
//   e_data       in   accumulator data word (NB_DATA)
//   e_overflow   in   accumulator overflow flag (level)
//   e_enable     in   1 = capture and timestamp run, 0 = frozen
//   e_clear      in   synchronous clear: flush FIFO, zero counters, clear drop
//   e_ready      in   consumer ready
//   s_valid      out  FIFO head valid
//   s_data       out  head snapshot data (NB_DATA)
//   s_tstamp     out  head snapshot timestamp (NB_TS)
//   s_level      out  FIFO occupancy (clog2(FIFO_DEPTH)+1)
//   s_event_cnt  out  saturating count of detected overflow events (NB_CNT)
//   s_drop       out  sticky: an event was lost because the FIFO was full
// ---------------------------------------------------------------------------
module acum_ovf_capture #(
  parameter int NB_DATA    = 7,
  parameter int NB_TS      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int NB_CNT     = 8
) (
  input  logic                          e_clk,
  input  logic                          e_reset,
  input  logic [NB_DATA-1:0]            e_data,
  input  logic                          e_overflow,
  input  logic                          e_enable,
  input  logic                          e_clear,
  input  logic                          e_ready,
  output logic                          s_valid,
  output logic [NB_DATA-1:0]            s_data,
  output logic [NB_TS-1:0]              s_tstamp,
  output logic [$clog2(FIFO_DEPTH):0]   s_level,
  output logic [NB_CNT-1:0]             s_event_cnt,
  output logic                          s_drop
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic                ovf_q;
  logic [NB_TS-1:0]    ts_q, ts_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  logic                drop_q, drop_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;

  logic [NB_DATA-1:0]  mem_data_q [FIFO_DEPTH];
  logic [NB_TS-1:0]    mem_ts_q   [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] wr_en;

  logic event_w, pop_w, full_w, push_w, lost_w;

  // One event per rising edge of the flag; ovf_q tracks the flag even when
  // disabled or clearing so a level held across either yields no new event.
  assign event_w = e_enable & e_overflow & ~ovf_q;
  assign full_w  = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop_w   = s_valid & e_ready & ~e_clear;
  // When full, a simultaneous pop frees the slot the push needs.
  assign push_w  = event_w & ~e_clear & (~full_w | pop_w);
  assign lost_w  = event_w & ~e_clear & full_w & ~pop_w;

  always_comb begin
    ts_d     = ts_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (e_clear) begin
      ts_d     = '0;
      cnt_d    = '0;
      drop_d   = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (e_enable)
        ts_d = ts_q + NB_TS'(1);
      if (event_w && (cnt_q != {NB_CNT{1'b1}}))
        cnt_d = cnt_q + NB_CNT'(1);
      if (lost_w)
        drop_d = 1'b1;
      // Power-of-two depth: pointer increment wraps naturally.
      if (push_w)
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_w)
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push_w) - LVL_W'(pop_w);
    end
  end

  always_ff @(posedge e_clk or negedge e_reset) begin
    if (!e_reset) begin
      ovf_q    <= 1'b0;
      ts_q     <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      ovf_q    <= e_overflow;
      ts_q     <= ts_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Per-entry write enables decoded from the write pointer.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push_w && (wr_ptr_q == PTR_W'(gi));
  end

  // Storage is reset so the head outputs read zero out of reset.
  always_ff @(posedge e_clk or negedge e_reset) begin
    if (!e_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_ts_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (wr_en[i]) begin
          mem_data_q[i] <= e_data;
          mem_ts_q[i]   <= ts_q;
        end
      end
    end
  end

  // Show-ahead head: purely from registered storage and pointers.
  assign s_valid     = (level_q != '0);
  assign s_data      = mem_data_q[rd_ptr_q];
  assign s_tstamp    = mem_ts_q[rd_ptr_q];
  assign s_level     = level_q;
  assign s_event_cnt = cnt_q;
  assign s_drop      = drop_q;

endmodule

// File: tb/tb_acum_ovf_capture.sv
module tb_acum_ovf_capture;

  localparam int DEPTH = 4;

  logic       e_clk;
  logic       e_reset;
  logic [6:0] e_data;
  logic       e_overflow, e_enable, e_clear, e_ready;
  logic       s_valid;
  logic [6:0] s_data;
  logic [7:0] s_tstamp;
  logic [2:0] s_level;
  logic [7:0] s_event_cnt;
  logic       s_drop;

  acum_ovf_capture #(.NB_DATA(7), .NB_TS(8), .FIFO_DEPTH(DEPTH), .NB_CNT(8)) dut (
    .e_clk(e_clk), .e_reset(e_reset), .e_data(e_data), .e_overflow(e_overflow),
    .e_enable(e_enable), .e_clear(e_clear), .e_ready(e_ready),
    .s_valid(s_valid), .s_data(s_data), .s_tstamp(s_tstamp), .s_level(s_level),
    .s_event_cnt(s_event_cnt), .s_drop(s_drop)
  );

  initial e_clk = 1'b0;
  always #5 e_clk = ~e_clk;

  int errors = 0;
  int checks = 0;

  typedef struct { int d; int t; } snap_t;
  snap_t sb[$];

  bit m_ovf  = 1'b0;
  int m_ts   = 0;
  int m_cnt  = 0;
  bit m_drop = 1'b0;

  typedef struct {
    bit ovf; int data; bit en; bit rdy; bit clr;
    bit ev; int el; int ec; bit ed; int ehd; int eht;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances at the edge and the DUT is
  // compared 1 time unit later.
  task automatic cycle(input bit ovf, input int data, input bit en, input bit rdy, input bit clr);
    bit ev, pop, full;
    e_overflow = ovf; e_data = data[6:0]; e_enable = en; e_ready = rdy; e_clear = clr;
    #1;
    if (rdy && !clr && sb.size() > 0) begin
      chk("pop_valid", s_valid, 1);
      chk("pop_data", s_data, sb[0].d);
      chk("pop_ts", s_tstamp, sb[0].t);
      $display("handshake data=%02h ts=%0d (exp %02h/%0d)", s_data, s_tstamp, sb[0].d, sb[0].t);
    end
    @(posedge e_clk);
    ev  = en && ovf && !m_ovf;
    pop = (sb.size() > 0) && rdy;
    if (clr) begin
      sb.delete(); m_ts = 0; m_cnt = 0; m_drop = 1'b0;
    end else begin
      full = (sb.size() == DEPTH);
      if (pop) void'(sb.pop_front());
      if (ev) begin
        if (full && !pop) m_drop = 1'b1;
        else sb.push_back('{d: data & 127, t: m_ts});
        if (m_cnt < 255) m_cnt++;
      end
      if (en) m_ts = (m_ts + 1) % 256;
    end
    m_ovf = ovf;
    #1;
    chk("valid", s_valid, sb.size() != 0);
    chk("level", s_level, sb.size());
    chk("event_cnt", s_event_cnt, m_cnt);
    chk("drop", s_drop, m_drop);
    if (sb.size() > 0) begin
      chk("head_data", s_data, sb[0].d);
      chk("head_ts", s_tstamp, sb[0].t);
    end
  endtask

  task automatic add(input bit ovf, input int data, input bit en, input bit rdy, input bit clr,
                     input bit ev, input int el, input int ec, input bit ed, input int ehd, input int eht);
    tbl.push_back('{ovf, data, en, rdy, clr, ev, el, ec, ed, ehd, eht});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    e_reset = 1'b0; e_data = '0; e_overflow = 1'b0; e_enable = 1'b0; e_clear = 1'b0; e_ready = 1'b0;

    // Vectors: inputs held for one cycle, expected outputs after that edge.
    for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 'h41, 1, 0, 0, 1, 1, 1, 0, 'h41, 5);   // rising edge at ts 5
    add(1, 'h10, 1, 0, 0, 1, 1, 1, 0, 'h41, 5);   // level held: no event
    add(1, 'h11, 1, 0, 0, 1, 1, 1, 0, 'h41, 5);
    add(0, 0,    1, 0, 0, 1, 1, 1, 0, 'h41, 5);
    add(1, 'h22, 1, 0, 0, 1, 2, 2, 0, 'h41, 5);
    add(0, 0,    1, 0, 0, 1, 2, 2, 0, 'h41, 5);
    add(1, 'h33, 1, 0, 0, 1, 3, 3, 0, 'h41, 5);
    add(0, 0,    1, 0, 0, 1, 3, 3, 0, 'h41, 5);
    add(1, 'h44, 1, 0, 0, 1, 4, 4, 0, 'h41, 5);
    add(0, 0,    1, 0, 0, 1, 4, 4, 0, 'h41, 5);
    add(1, 'h55, 1, 0, 0, 1, 4, 5, 1, 'h41, 5);   // full: dropped
    add(0, 0,    1, 0, 0, 1, 4, 5, 1, 'h41, 5);
    add(1, 'h66, 1, 1, 0, 1, 4, 6, 1, 'h22, 9);   // full, push+pop
    add(0, 0,    1, 0, 0, 1, 4, 6, 1, 'h22, 9);
    add(0, 0,    1, 1, 0, 1, 3, 6, 1, 'h33, 11);  // drain
    add(0, 0,    1, 1, 0, 1, 2, 6, 1, 'h44, 13);
    add(0, 0,    1, 1, 0, 1, 1, 6, 1, 'h66, 17);
    add(0, 0,    1, 1, 0, 0, 0, 6, 1, 0, 0);
    add(0, 0,    1, 1, 0, 0, 0, 6, 1, 0, 0);       // ready while empty

    @(posedge e_clk); @(posedge e_clk); #1;
    chk("rst_valid", s_valid, 0);
    chk("rst_level", s_level, 0);
    chk("rst_cnt", s_event_cnt, 0);
    chk("rst_drop", s_drop, 0);
    chk("rst_data", s_data, 0);
    chk("rst_ts", s_tstamp, 0);
    e_reset = 1'b1;

    foreach (tbl[i]) begin
      cycle(tbl[i].ovf, tbl[i].data, tbl[i].en, tbl[i].rdy, tbl[i].clr);
      $display("vec %0d: valid=%0d level=%0d cnt=%0d drop=%0d head=%02h/%0d", i,
               s_valid, s_level, s_event_cnt, s_drop, s_data, s_tstamp);
      chk("tbl_valid", s_valid, tbl[i].ev);
      chk("tbl_level", s_level, tbl[i].el);
      chk("tbl_cnt", s_event_cnt, tbl[i].ec);
      chk("tbl_drop", s_drop, tbl[i].ed);
      if (tbl[i].ev) begin
        chk("tbl_data", s_data, tbl[i].ehd);
        chk("tbl_ts", s_tstamp, tbl[i].eht);
      end
    end

    // Counter saturation: 260 events, drained as they arrive.
    cycle(0, 0, 1, 0, 1);
    for (int i = 0; i < 260; i++) begin
      cycle(1, i & 127, 1, 1, 0);
      cycle(0, 0, 1, 1, 0);
    end
    chk("sat_cnt", s_event_cnt, 255);

    // Timestamp wrap: 259 enabled cycles from 0, then capture.
    cycle(0, 0, 1, 1, 1);
    for (int i = 0; i < 259; i++) cycle(0, 0, 1, 1, 0);
    cycle(1, 'h5A, 1, 0, 0);
    chk("wrap_ts", s_tstamp, 3);
    chk("wrap_data", s_data, 'h5A);

    // Disabled: no events, timestamp frozen, pops still drain.
    cycle(0, 0, 0, 0, 0);
    cycle(1, 'h11, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    chk("dis_cnt", s_event_cnt, 1);
    chk("dis_level", s_level, 0);
    cycle(1, 'h2B, 1, 0, 0);
    chk("frozen_ts", s_tstamp, 4);
    cycle(0, 0, 1, 1, 0);

    // Clear with an event and two entries queued, drop flag set.
    cycle(0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 'h60 + i, 1, 0, 0);
      cycle(0, 0, 1, 0, 0);
    end
    chk("pre_clr_drop", s_drop, 1);
    cycle(0, 0, 1, 1, 0);
    cycle(0, 0, 1, 1, 0);
    chk("pre_clr_level", s_level, 2);
    cycle(1, 'h77, 1, 1, 1);
    chk("clr_level", s_level, 0);
    chk("clr_cnt", s_event_cnt, 0);
    chk("clr_drop", s_drop, 0);
    chk("clr_valid", s_valid, 0);
    cycle(1, 'h78, 1, 0, 0);
    chk("held_cnt", s_event_cnt, 0);
    cycle(0, 0, 1, 0, 0);

    // Asynchronous reset mid-cycle with the head valid.
    cycle(1, 'h19, 1, 0, 0);
    chk("pre_arst_valid", s_valid, 1);
    #3 e_reset = 1'b0;
    #1;
    chk("arst_valid", s_valid, 0);
    chk("arst_level", s_level, 0);
    chk("arst_cnt", s_event_cnt, 0);
    chk("arst_data", s_data, 0);
    chk("arst_ts", s_tstamp, 0);
    sb.delete(); m_ts = 0; m_cnt = 0; m_drop = 1'b0; m_ovf = 1'b0;
    e_overflow = 1'b0; e_data = '0;
    @(posedge e_clk); #1;
    e_reset = 1'b1;
    cycle(1, 'h2A, 1, 0, 0);
    chk("post_rst_ts", s_tstamp, 0);
    cycle(0, 0, 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
